// File: rtl/round_step_scheduler_pkg.sv
// Shared constants and state encoding for the Keccak round/step scheduler.
// The ERROR state exists only when STEP_TIMEOUT_EN is defined.
package round_step_scheduler_pkg;

    localparam int NUM_STEPS_DEF  = 5;
    localparam int NUM_ROUNDS_DEF = 24;

    localparam int STEP_THETA = 0;
    localparam int STEP_RHO   = 1;
    localparam int STEP_PI    = 2;
    localparam int STEP_CHI   = 3;
    localparam int STEP_IOTA  = 4;

    localparam int LANE_BITS   = 64;
    localparam int STATE_CELLS = 25 * LANE_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_GAP   = 3'd2,
        ST_VALID = 3'd3
`ifdef STEP_TIMEOUT_EN
        ,
        ST_ERROR = 3'd4
`endif
    } state_e;

    function automatic logic [7:0] step_onehot(input logic [2:0] idx);
        return 8'(1) << idx;
    endfunction

endpackage

// File: rtl/round_step_scheduler_if.sv
// Control/strobe bundle between the scheduler and the step datapaths.
// master = scheduler side, slave = controller / datapath side.
interface round_step_scheduler_if
    import round_step_scheduler_pkg::*;
#(
    parameter int NUM_STEPS = NUM_STEPS_DEF
);
    logic                 start;
    logic                 ready;
    logic [NUM_STEPS-1:0] step_done;
    logic [NUM_STEPS-1:0] step_count;
    logic [NUM_STEPS-1:0] step_write;
    logic [2:0]           step_sel;
    logic [4:0]           round;
    logic                 out_valid;
    logic                 out_ack;
    logic                 error;

    modport master (
        input  start, step_done, out_ack,
        output ready, step_count, step_write, step_sel,
        output round, out_valid, error
    );

    modport slave (
        output start, step_done, out_ack,
        input  ready, step_count, step_write, step_sel,
        input  round, out_valid, error
    );

endinterface

// File: rtl/round_step_scheduler_counter.sv
// Wrapping up-counter with enable, programmable max and overflow flag.
// Clear has priority over enable.
module round_step_scheduler_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] max,
    output logic [W-1:0] count,
    output logic         ovf
);
    logic [W-1:0] count_q, count_d;

    assign ovf   = (count_q == max);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = ovf ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/round_step_scheduler.sv
// Keccak round/step sequencer: one-hot count/write strobes per step, a gap
// cycle between steps, valid/ack result. Optional watchdog: STEP_TIMEOUT_EN.
module round_step_scheduler
    import round_step_scheduler_pkg::*;
#(
    parameter int NUM_STEPS  = NUM_STEPS_DEF,
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
`ifdef STEP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2048
`endif
) (
    input logic                    clk,
    input logic                    rst,
    round_step_scheduler_if.master bus
);
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
    localparam logic [2:0] FIRST_STEP = 3'(STEP_THETA);

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [4:0] round_cnt;
    logic       round_ovf;
    logic       round_en;
    logic       round_clr;

    assign round_en  = (state_q == ST_GAP) && (step_q == LAST_STEP) && !round_ovf;
    // Rewind at ack so IDLE always shows the reset-time outputs.
    assign round_clr = (state_q == ST_VALID) && bus.out_ack;

    round_step_scheduler_counter #(.W(5)) u_round (
        .clk   (clk),
        .rst   (rst),
        .clr   (round_clr),
        .en    (round_en),
        .max   (5'(NUM_ROUNDS - 1)),
        .count (round_cnt),
        .ovf   (round_ovf)
    );

`ifdef STEP_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_unused;
    logic            wd_ovf;

    round_step_scheduler_counter #(.W(WD_W)) u_wd (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != ST_RUN),
        .en    (state_q == ST_RUN),
        .max   (WD_W'(TIMEOUT_CYCLES - 1)),
        .count (wd_cnt_unused),
        .ovf   (wd_ovf)
    );
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    step_d  = FIRST_STEP;
                end
            end
            ST_RUN: begin
                if (bus.step_done[step_q]) begin
                    state_d = ST_GAP;
                end
`ifdef STEP_TIMEOUT_EN
                else if (wd_ovf) begin
                    state_d = ST_ERROR;
                end
`endif
            end
            ST_GAP: begin
                if (step_q != LAST_STEP) begin
                    step_d  = step_q + 3'd1;
                    state_d = ST_RUN;
                end else if (!round_ovf) begin
                    step_d  = FIRST_STEP;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                if (bus.out_ack) begin
                    state_d = ST_IDLE;
                    step_d  = FIRST_STEP;
                end
            end
`ifdef STEP_TIMEOUT_EN
            ST_ERROR: state_d = ST_ERROR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= FIRST_STEP;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    assign bus.ready      = (state_q == ST_IDLE);
    assign bus.step_count = (state_q == ST_RUN) ? NUM_STEPS'(step_onehot(step_q)) : '0;
    assign bus.step_write = bus.step_count;
    assign bus.step_sel   = step_q;
    assign bus.round      = round_cnt;
    assign bus.out_valid  = (state_q == ST_VALID);
`ifdef STEP_TIMEOUT_EN
    assign bus.error      = (state_q == ST_ERROR);
`else
    assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_round_step_scheduler.sv
// Bench for round_step_scheduler: random step latencies, spurious inputs,
// ack hold, mid-run reset and (with STEP_TIMEOUT_EN) the watchdog.
module tb_round_step_scheduler;
    localparam int NS = 5;
    localparam int NR = 24;
`ifdef STEP_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    round_step_scheduler_if #(.NUM_STEPS(NS)) bus ();

`ifdef STEP_TIMEOUT_EN
    round_step_scheduler #(
        .NUM_STEPS(NS), .NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    round_step_scheduler #(
        .NUM_STEPS(NS), .NUM_ROUNDS(NR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] obs();
        return {bus.ready, bus.step_count, bus.step_write, bus.step_sel,
                bus.round, bus.out_valid, bus.error};
    endfunction

    // Expected observable vector from the abstract position in the sequence.
    function automatic logic [20:0] vec(input bit rdy, input int sel, input int rnd,
                                        input bit stb, input bit vld, input bit err);
        logic [NS-1:0] oh;
        oh = stb ? NS'(1 << sel) : '0;
        return {rdy, oh, oh, 3'(sel), 5'(rnd), vld, err};
    endfunction

    // Step k of the whole permutation is step k%NS of round k/NS.
    task automatic drive_perm(input int dfix, input int abort_k);
        logic [NS-1:0] cur;
        int            d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < NS * NR; k++) begin
            d   = (dfix > 0) ? dfix : int'($urandom_range(1, 10));
            cur = NS'(1 << (k % NS));
            for (int c = 1; c <= d; c++) begin
                total++;
                if (obs() !== vec(1'b0, k % NS, k / NS, 1'b1, 1'b0, 1'b0)) begin
                    bad++;
                    $display("FAIL run k=%0d c=%0d got=%h want=%h", k, c, obs(),
                             vec(1'b0, k % NS, k / NS, 1'b1, 1'b0, 1'b0));
                end
                if (k == abort_k && c == 1) begin
                    rst           = 1'b1;
                    bus.start     = 1'b0;
                    bus.step_done = '0;
                    bus.out_ack   = 1'b0;
                    tick();
                    rst = 1'b0;
                    total++;
                    if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
                        bad++;
                        $display("FAIL mid_reset got=%h want=%h", obs(),
                                 vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
                    end
                    return;
                end
                bus.step_done = ((c == d) ? cur : '0) | (NS'($urandom) & ~cur);
                bus.start     = 1'($urandom);
                bus.out_ack   = 1'($urandom);
                tick();
            end
            total++;
            if (obs() !== vec(1'b0, k % NS, k / NS, 1'b0, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL gap k=%0d got=%h want=%h", k, obs(),
                         vec(1'b0, k % NS, k / NS, 1'b0, 1'b0, 1'b0));
            end
            bus.step_done = NS'($urandom);
            bus.start     = 1'($urandom);
            bus.out_ack   = 1'($urandom);
            tick();
        end
        bus.step_done = '0;
        bus.start     = 1'b0;
        bus.out_ack   = 1'b0;
    endtask

    task automatic test_valid_ack(input int hold);
        for (int i = 0; i < hold; i++) begin
            total++;
            if (obs() !== vec(1'b0, NS - 1, NR - 1, 1'b0, 1'b1, 1'b0)) begin
                bad++;
                $display("FAIL valid_hold i=%0d got=%h want=%h", i, obs(),
                         vec(1'b0, NS - 1, NR - 1, 1'b0, 1'b1, 1'b0));
            end
            bus.step_done = NS'($urandom);
            bus.start     = 1'($urandom);
            bus.out_ack   = 1'b0;
            tick();
        end
        total++;
        if (obs() !== vec(1'b0, NS - 1, NR - 1, 1'b0, 1'b1, 1'b0)) begin
            bad++;
            $display("FAIL valid_last got=%h want=%h", obs(),
                     vec(1'b0, NS - 1, NR - 1, 1'b0, 1'b1, 1'b0));
        end
        bus.out_ack   = 1'b1;
        bus.start     = 1'b1;
        bus.step_done = '0;
        tick();
        bus.out_ack = 1'b0;
        bus.start   = 1'b0;
        total++;
        if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL ack_idle got=%h want=%h", obs(),
                     vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
        end
        tick();
        total++;
        if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL start_on_ack got=%h want=%h", obs(),
                     vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        tick();
        tick();
        total++;
        if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs(), vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.step_done = NS'($urandom);
            bus.out_ack   = 1'($urandom);
            tick();
            total++;
            if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL idle i=%0d got=%h want=%h", i, obs(),
                         vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
            end
        end
        bus.step_done = '0;
        bus.out_ack   = 1'b0;
    endtask

    task automatic test_sequence();
        drive_perm(6, -1);
        test_valid_ack(7);
    endtask

    task automatic test_random_steps();
        drive_perm(0, -1);
        test_valid_ack(0);
    endtask

    task automatic test_mid_reset();
        drive_perm(0, 11 * NS + 2);
        tick();
        drive_perm(3, -1);
        test_valid_ack(int'($urandom_range(0, 3)));
    endtask

    task automatic test_back_to_back();
        drive_perm(1, -1);
        test_valid_ack(0);
        drive_perm(0, -1);
        test_valid_ack(1);
    endtask

`ifdef STEP_TIMEOUT_EN
    task automatic test_timeout();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < TO; c++) begin
            total++;
            if (obs() !== vec(1'b0, 0, 0, 1'b1, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL wd_run c=%0d got=%h want=%h", c, obs(),
                         vec(1'b0, 0, 0, 1'b1, 1'b0, 1'b0));
            end
            bus.step_done = NS'($urandom) & ~NS'(1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs() !== vec(1'b0, 0, 0, 1'b0, 1'b0, 1'b1)) begin
                bad++;
                $display("FAIL wd_error i=%0d got=%h want=%h", i, obs(),
                         vec(1'b0, 0, 0, 1'b0, 1'b0, 1'b1));
            end
            bus.start     = 1'b1;
            bus.step_done = NS'($urandom);
            tick();
        end
        bus.start     = 1'b0;
        bus.step_done = '0;
        rst           = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (obs() !== vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL wd_reset got=%h want=%h", obs(), vec(1'b1, 0, 0, 1'b0, 1'b0, 1'b0));
        end
    endtask
`endif

    initial begin
        bus.start     = 1'b0;
        bus.step_done = '0;
        bus.out_ack   = 1'b0;
        test_reset();
        test_sequence();
        test_random_steps();
        test_mid_reset();
        test_back_to_back();
`ifdef STEP_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_step_scheduler.md
# round_step_scheduler

Sequencing controller for the Keccak permutation datapaths. It drives the per-step `count`/`write` strobes of NUM_STEPS step datapaths in order (theta column parity, rho, pi, chi, iota) and waits for each step's `done`. It repeats the sequence for NUM_ROUNDS rounds, then presents the result with a valid/ack handshake. It sits between the top-level control and the step datapaths and also drives the routing select that feeds each step's `data_in` from the previous step's `data_out`.

## Interface
- NUM_STEPS, 5, number of step datapaths per round
- NUM_ROUNDS, 24, rounds per permutation
- TIMEOUT_CYCLES, 2048, watchdog limit per step (used only with STEP_TIMEOUT_EN)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request a permutation; accepted only when `ready`=1
- ready  out  1  high in IDLE only
- step_done  in  NUM_STEPS  per-step `done`; a bit is used only while that step is current
- step_count  out  NUM_STEPS  one-hot `count` strobe to the current step
- step_write  out  NUM_STEPS  one-hot `write` strobe to the current step, identical to step_count
- step_sel  out  3  index of the current step; routing mux select
- round  out  5  current round index, 0..NUM_ROUNDS-1
- out_valid  out  1  permutation result is stable
- out_ack  in  1  consumer accepts the result
- error  out  1  sticky watchdog error; tied 0 without STEP_TIMEOUT_EN

## Operation
- States: IDLE, RUN, GAP, VALID, ERROR. ERROR exists only with STEP_TIMEOUT_EN.
- IDLE: `ready`=1 and all strobes are 0. When `start`=1, go to RUN with step=0 and round=0.
- RUN: `step_count[step]`=`step_write[step]`=1 every cycle. When `step_done[step]`=1 is sampled, that cycle carries the final cell write; go to GAP next cycle.
- GAP: one cycle with all strobes 0, so the written memory is readable by the next step.
  - If step<NUM_STEPS-1: step+1, then RUN.
  - Else if round<NUM_ROUNDS-1: step=0, round+1, then RUN.
  - Else: go to VALID.
- VALID: `out_valid`=1. Hold `step_sel`=NUM_STEPS-1 and `round`=NUM_ROUNDS-1. When `out_ack`=1, go to IDLE next cycle.
- The following are ignored:
  - `start` outside IDLE
  - `step_done` bits of non-current steps
  - any `step_done` bit in IDLE, GAP or VALID
  - `out_ack` outside VALID
- Width rules: `step` wraps from NUM_STEPS-1 to 0; `round` never exceeds NUM_ROUNDS-1. Both are unsigned and compared with equality.

## Timing
- Reset values: `ready`=1. `step_count`, `step_write`, `step_sel`, `round`, `out_valid` and `error` are all 0. State is IDLE.
- Reset mid-operation returns to IDLE in the next cycle with the reset values above. The step datapaths share `rst`, so their counters restart in sync.
- Outputs are registered state decodes. The first RUN cycle is the cycle after `start` is sampled.
- With D = cycles from a step's first `count` to its `done` inclusive (1600 for a 5×5×64 state), `out_valid` rises NUM_ROUNDS·NUM_STEPS·(D+1) cycles after the first RUN cycle.
- `out_ack` in the first VALID cycle is legal. `ready` is high in the following cycle, and a new `start` is accepted no earlier than that.

## Configuration
- STEP_TIMEOUT_EN defined:
  - A watchdog counter clears on every entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without the current `step_done`, go to ERROR.
  - ERROR sets `error`=1, drives all strobes 0, `ready`=0 and `out_valid`=0.
  - ERROR exits only via `rst`.
- STEP_TIMEOUT_EN undefined: no watchdog logic, no ERROR state, `error` tied to 0.

## Structure
- The shared header `ISA.v` holds:
  - the state encodings
  - NUM_STEPS and NUM_ROUNDS defaults
  - step index constants STEP_THETA=0, STEP_RHO=1, STEP_PI=2, STEP_CHI=3, STEP_IOTA=4
  - the cell-count constants already used by the datapaths
- Round and watchdog counting reuse the existing `Counter` sub-module (enable, max, overflow). No other sub-modules.

## Test plan
- Reset then idle, 10 cycles → `ready`=1; `step_count`=0, `round`=0, `out_valid`=0 throughout.
- `start` pulse, step models assert `done` at cycle D=1600 → `step_count` = 00001, then a 1-cycle gap, then 00010, and so on. `round` increments after each STEP_IOTA. `out_valid` rises exactly 120·1601 cycles after the first RUN cycle.
- `out_ack` held low for 7 VALID cycles, then pulsed → `out_valid` stays high for 8 cycles, then IDLE with `ready`=1. A `start` on the ack cycle is ignored.
- Spurious `step_done[3]` during step 0, and `start` asserted mid-RUN → no state change; sequence timing unchanged.
- `rst` asserted during round 11, step 2 → next cycle IDLE with all outputs at reset values. A fresh `start` completes normally.
- With STEP_TIMEOUT_EN and TIMEOUT_CYCLES=16, a step model never asserts `done` → `error`=1 after 16 RUN cycles, strobes 0, `ready`=0. `start` is ignored until `rst`.
